serial_add_seq: RTL



---
 rtl/serial_add_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/serial_add_seq.sv
// -----------------------------------------------------------------------------
// serial_add_seq
//
// Bit-serial adder sequencer. Two WIDTH-bit operands are accepted on an
// input handshake, then added LSB-first one bit per clock. Each bit goes
// through two half-adder stages with a registered carry. The serial sum bits
// are assembled into a WIDTH-bit result. That result and its carry-out are
// offered on an output handshake.
//
// Handshake semantics (both sides): a transfer happens on a rising clock edge
// where valid and ready are both high. Once valid is raised, the producer
// holds it and its data stable until that transfer. The ready outputs of
// this block (in_ready) and its valid outputs (out_valid) are decoded from
// FSM state only. They never depend combinationally on in_valid or out_ready.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   operand source presents a/b
//   in_ready    out  block can accept operands (IDLE only)
//   a, b        in   WIDTH-bit operands
//   out_valid   out  sum/cout hold a completed result (DONE only)
//   out_ready   in   consumer accepts the result
//   sum         out  a + b modulo 2^WIDTH
//   cout        out  carry out of bit WIDTH-1
//   busy        out  high in RUN or DONE
//   dbg_state_o out  current FSM state code (IDLE=0, RUN=1, DONE=2)
//
// Legal WIDTH range is 1..32.
// -----------------------------------------------------------------------------
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic [1:0]       dbg_state_o
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  // Single bit of add logic: two half adders and a carry merge.
  logic             ha1_p, ha1_g;
  logic             ha2_s, ha2_g;
  logic             carry_nxt;
  logic [WIDTH-1:0] acc_shift;

  always_comb begin
    ha1_p     = sa_q[0] ^ sb_q[0];
    ha1_g     = sa_q[0] & sb_q[0];
    ha2_s     = ha1_p ^ c_q;
    ha2_g     = ha1_p & c_q;
    carry_nxt = ha1_g | ha2_g;
    // The new sum bit enters at the MSB and everything moves down one place,
    // so after WIDTH shifts bit i sits at position i. Going through a
    // WIDTH+1 bit concatenation keeps this legal for WIDTH == 1.
    acc_shift = WIDTH'({ha2_s, acc_q} >> 1);
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sa_d    = a;
          sb_d    = b;
          c_d     = 1'b0;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        c_d   = carry_nxt;
        acc_d = acc_shift;
        if (cnt_q == CNT_LAST) begin
          // The visible result registers change only here. Between
          // operations they keep the last completed sum.
          sum_d   = acc_shift;
          cout_d  = carry_nxt;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign busy        = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign dbg_state_o = state_q;

endmodule
